uart_transmitter: RTL

Serial UART transmitter, the transmit-side counterpart of the team's 8-bit even-parity UART receiver. It accepts bytes over a valid/ready handshake into a small internal FIFO and serialises each byte as a single frame: one start bit, 8 data bits LSB first, one even-parity bit, one stop bit. It sits between the CPU/top-level logic and the board TX line. Its output must be decodable by the receiver, which flags a parity error when (^data[7:0]) != parity.

---
 rtl/uart_transmitter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
// UART transmitter: byte FIFO in front of an 8-data-bit, even-parity, one-stop-bit
// serialiser. tx and busy are registered so the line never glitches.
module uart_transmitter #(
    parameter int BAUD_RATE      = 9600,
    parameter int CLOCK_FREQ     = 50000000,
    parameter int CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state, state_n;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_n;
    logic [15:0]     baud, baud_n;
    logic [2:0]      bit_idx, bit_n;
    logic [7:0]      shift, shift_n;
    logic            parity, parity_n;
    logic            tx_n;
    logic            push, pop, can_pop, bit_end;
    logic [7:0]      head;

    assign push    = tx_valid & tx_ready;
    assign can_pop = enable & (count != '0);
    assign bit_end = (baud == 16'(CYCLES_PER_BIT - 1));
    assign head    = mem[rd_ptr];

    always_comb begin
        state_n  = state;
        shift_n  = shift;
        parity_n = parity;
        bit_n    = bit_idx;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (can_pop) begin
                    pop      = 1'b1;
                    state_n  = START;
                    shift_n  = head;
                    parity_n = ^head;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) state_n = PARITY;
                    else                 bit_n   = bit_idx + 3'd1;
                end
            end
            PARITY: begin
                if (bit_end) state_n = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (can_pop) begin
                        pop      = 1'b1;
                        state_n  = START;
                        shift_n  = head;
                        parity_n = ^head;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // tx is derived from the next-state values so the registered line
        // changes on the same edge as the state it represents.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = parity_n;
            default: tx_n = 1'b1;
        endcase

        if (state == IDLE || state_n != state || bit_end) baud_n = '0;
        else                                              baud_n = baud + 16'd1;

        case ({push, pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            parity   <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx_ready <= 1'b1;
        end else begin
            state    <= state_n;
            baud     <= baud_n;
            bit_idx  <= bit_n;
            shift    <= shift_n;
            parity   <= parity_n;
            tx       <= tx_n;
            busy     <= (state_n != IDLE);
            count    <= count_n;
            tx_ready <= (count_n != CW'(FIFO_DEPTH));
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    assign fifo_count = count;

endmodule
